// File: rtl/riscv_multicycle_sequencer_pkg.sv
// Shared control definitions for the RV32I multi-cycle sequencer:
// opcodes, state encoding and the pc_sel / wb_sel / alu_op codes.
package riscv_multicycle_sequencer_pkg;

    typedef logic [6:0] opcode_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_IMM    = 7'b0010011;
    localparam opcode_t OP_OP     = 7'b0110011;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] ALU_ARITH  = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_ADDR   = 2'b10;

    function automatic logic opcode_legal(input opcode_t op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_sequencer_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
interface riscv_multicycle_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/riscv_multicycle_sequencer_mem_wait_timer.sv
// Memory wait counter: cleared per access, counts stalled cycles, flags the limit.
module riscv_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

    logic [W-1:0] cnt;

    // A zero limit never expires, so an access may wait indefinitely.
    assign expired = (MEM_TIMEOUT != 0) && (cnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (count && !expired && (MEM_TIMEOUT != 0))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/riscv_multicycle_sequencer.sv
// RV32I multi-cycle control sequencer sharing one memory port for fetch and load/store.
// Define RISCV_SEQ_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
//
// state  | meaning
// IDLE   | stopped at an instruction boundary, waiting for run
// FETCH  | memory read at PC, IR latched on mem_ready
// DECODE | opcode legality check
// EXEC   | ALU operation; branches retire here
// MEM    | load/store at ALU address; stores retire here
// WB     | register write-back and PC update, retire
// TRAP   | illegal opcode or memory timeout; left only by reset
module riscv_multicycle_sequencer
    import riscv_multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    riscv_multicycle_sequencer_if.master mem,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       illegal,
    output logic       retire
`ifdef RISCV_SEQ_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    logic [2:0] state, state_nxt;
    logic       mem_req_c, mem_we_c, mem_addr_sel_c;
    logic       wait_clr, wait_cnt_en, wait_expired;
    logic       is_load, is_store;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);

    // Any state change starts a fresh access window for the wait counter.
    assign wait_clr    = (state_nxt != state);
    assign wait_cnt_en = mem_req_c & ~mem.mem_ready;

    riscv_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clr),
        .count   (wait_cnt_en),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        pc_sel         = PC_PLUS4;
        reg_we         = 1'b0;
        wb_sel         = WB_ALU;
        alu_src        = 1'b0;
        alu_op         = ALU_ARITH;
        retire         = 1'b0;
        case (state)
            ST_IDLE: if (run) state_nxt = ST_FETCH;
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_we     = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (wait_expired) begin
                    state_nxt = ST_TRAP;
                end
            end
            ST_DECODE: state_nxt = opcode_legal(opcode) ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (opcode)
                    OP_OP:     begin alu_src = 1'b0; alu_op = ALU_ARITH;  end
                    OP_BRANCH: begin alu_src = 1'b0; alu_op = ALU_BRANCH; end
                    OP_LOAD, OP_STORE, OP_AUIPC, OP_JAL, OP_JALR:
                               begin alu_src = 1'b1; alu_op = ALU_ADDR;   end
                    default:   begin alu_src = 1'b1; alu_op = ALU_ARITH;  end
                endcase
                if (opcode == OP_BRANCH) begin
                    pc_we     = 1'b1;
                    pc_sel    = branch_taken ? PC_BRANCH : PC_PLUS4;
                    retire    = 1'b1;
                    state_nxt = run ? ST_FETCH : ST_IDLE;
                end else if (is_load || is_store) begin
                    state_nxt = ST_MEM;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = is_store;
                if (mem.mem_ready) begin
                    if (is_store) begin
                        pc_we     = 1'b1;
                        retire    = 1'b1;
                        state_nxt = run ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_nxt = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_nxt = run ? ST_FETCH : ST_IDLE;
                case (opcode)
                    OP_LOAD: wb_sel = WB_MEM;
                    OP_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_JAL;  end
                    OP_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR; end
                    OP_LUI:  wb_sel = WB_IMM;
                    default: wb_sel = WB_ALU;
                endcase
            end
            ST_TRAP: state_nxt = ST_TRAP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem.mem_req      = mem_req_c;
    assign mem.mem_we       = mem_we_c;
    assign mem.mem_addr_sel = mem_addr_sel_c;
    assign busy             = (state != ST_IDLE) && (state != ST_TRAP);
    assign illegal          = (state == ST_TRAP);

`ifdef RISCV_SEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (busy)   cycle_cnt   <= cycle_cnt + 32'd1;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule
